fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_stage_ifid_reg.sv | 35 +++
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch stage and its IF/ID register.
// Field positions follow the 16-bit OP/RS/RT/RD instruction layout.
package fetch_stage_pkg;

    localparam int PC_W_DEF    = 16;
    localparam int INSTR_W_DEF = 16;

    localparam logic [15:0] NOP = 16'h0000;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RS_HI = 11;
    localparam int RS_LO = 8;
    localparam int RT_HI = 7;
    localparam int RT_LO = 4;
    localparam int RD_HI = 3;
    localparam int RD_LO = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// Pipeline register with load, hold and flush-to-bubble controls.
// A flush clears instr/valid but keeps pc_plus; flush beats load.
module fetch_stage_ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int PC_W    = PC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr,
    input  logic [PC_W-1:0]    pc_plus,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc_plus,
    output logic               ifid_valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_instr   <= INSTR_W'(NOP);
            ifid_pc_plus <= '0;
            ifid_valid   <= 1'b0;
        end else if (flush) begin
            ifid_instr <= INSTR_W'(NOP);
            ifid_valid <= 1'b0;
        end else if (load) begin
            ifid_instr   <= instr;
            ifid_pc_plus <= pc_plus;
            ifid_valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and one-entry hold buffer.
// Define FETCH_STATS_EN to add the StallCnt/BubbleCnt counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCWrite,
    input  logic               IFIDWrite,
    input  logic               BrTaken,
    input  logic [PC_W-1:0]    BrTarget,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic [INSTR_W-1:0] IFIDInstr,
    output logic [PC_W-1:0]    IFIDPCPlus,
    output logic               IFIDValid,
    output logic [3:0]         IDRegRs,
    output logic [3:0]         IDRegRt
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]        StallCnt,
    output logic [15:0]        BubbleCnt
`endif
);

    fetch_state_e       state;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus;
    logic [INSTR_W-1:0] hold_buf;
    logic               buf_full;
    logic               in_fetch;
    logic               in_hold;
    logic               deliver;
    logic               advance;
    logic               flush;
    logic               load;
    logic [INSTR_W-1:0] load_instr;

    assign pc_plus  = pc + PC_W'(1);
    assign in_fetch = (state == FETCH);
    assign in_hold  = (state == HOLD);

    // PC only moves when an instruction is actually consumed by IF/ID
    assign deliver = IFIDWrite &&
                     ((in_fetch && imem_ack) || (in_hold && buf_full));
    assign advance = deliver && PCWrite;

    assign flush = !rst &&
                   (BrTaken || (in_fetch && !imem_ack && IFIDWrite));
    assign load  = !rst && !BrTaken && deliver;

    assign load_instr = in_hold ? hold_buf : imem_rdata;
    assign imem_addr  = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            imem_req <= 1'b0;
            buf_full <= 1'b0;
            hold_buf <= '0;
        end else if (BrTaken) begin
            pc       <= BrTarget;
            buf_full <= 1'b0;
            state    <= FETCH;
            imem_req <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack && !IFIDWrite) begin
                        hold_buf <= imem_rdata;
                        buf_full <= 1'b1;
                        state    <= HOLD;
                        imem_req <= 1'b0;
                    end else if (advance) begin
                        pc <= pc_plus;
                    end
                end
                HOLD: begin
                    if (IFIDWrite) begin
                        buf_full <= 1'b0;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                        if (PCWrite) pc <= pc_plus;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    fetch_stage_ifid_reg #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W)
    ) u_ifid_reg (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .flush        (flush),
        .instr        (load_instr),
        .pc_plus      (pc_plus),
        .ifid_instr   (IFIDInstr),
        .ifid_pc_plus (IFIDPCPlus),
        .ifid_valid   (IFIDValid)
    );

    assign IDRegRs = IFIDInstr[RS_HI:RS_LO];
    assign IDRegRt = IFIDInstr[RT_HI:RT_LO];

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCnt  <= '0;
            BubbleCnt <= '0;
        end else begin
            if (!IFIDWrite && StallCnt != 16'hFFFF)
                StallCnt <= StallCnt + 16'd1;
            if (flush && BubbleCnt != 16'hFFFF)
                BubbleCnt <= BubbleCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stream, stall, redirect, wait states,
// PC wrap and reset in HOLD, each step with hand-computed expectations.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        BrTaken;
    logic [15:0] BrTarget;
    logic        ack_en;

    logic        req_a, ack_a, valid_a;
    logic [15:0] addr_a, rdata_a, instr_a, pcplus_a;
    logic [3:0]  rs_a, rt_a;

    logic        req_b, ack_b, valid_b;
    logic [15:0] addr_b, rdata_b, instr_b, pcplus_b;
    logic [3:0]  rs_b, rt_b;

`ifdef FETCH_STATS_EN
    logic [15:0] stall_a, bubble_a, stall_b, bubble_b;
`endif

    int n_run  = 0;
    int n_fail = 0;
    int fetch5 = 0;
    logic leak = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return {4'h3, a[3:0], a[7:4], a[11:8]};
    endfunction

    assign ack_a   = req_a && ack_en;
    assign rdata_a = ack_a ? mem(addr_a) : 16'hDEAD;
    assign ack_b   = req_b;
    assign rdata_b = ack_b ? mem(addr_b) : 16'hDEAD;

    fetch_stage u_dut (
        .clk        (clk),
        .rst        (rst),
        .PCWrite    (PCWrite),
        .IFIDWrite  (IFIDWrite),
        .BrTaken    (BrTaken),
        .BrTarget   (BrTarget),
        .imem_req   (req_a),
        .imem_addr  (addr_a),
        .imem_rdata (rdata_a),
        .imem_ack   (ack_a),
        .IFIDInstr  (instr_a),
        .IFIDPCPlus (pcplus_a),
        .IFIDValid  (valid_a),
        .IDRegRs    (rs_a),
        .IDRegRt    (rt_a)
`ifdef FETCH_STATS_EN
        ,
        .StallCnt   (stall_a),
        .BubbleCnt  (bubble_a)
`endif
    );

    fetch_stage #(.RESET_PC(16'hFFFF)) u_wrap (
        .clk        (clk),
        .rst        (rst),
        .PCWrite    (PCWrite),
        .IFIDWrite  (IFIDWrite),
        .BrTaken    (BrTaken),
        .BrTarget   (BrTarget),
        .imem_req   (req_b),
        .imem_addr  (addr_b),
        .imem_rdata (rdata_b),
        .imem_ack   (ack_b),
        .IFIDInstr  (instr_b),
        .IFIDPCPlus (pcplus_b),
        .IFIDValid  (valid_b),
        .IDRegRs    (rs_b),
        .IDRegRt    (rt_b)
`ifdef FETCH_STATS_EN
        ,
        .StallCnt   (stall_b),
        .BubbleCnt  (bubble_b)
`endif
    );

    always @(posedge clk) begin
        if (!rst && req_a && ack_a && addr_a == 16'h0005)
            fetch5 <= fetch5 + 1;
        if (valid_a && instr_a == 16'h3600)
            leak <= 1'b1;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        BrTaken   = 1'b0;
        BrTarget  = 16'h0000;
        ack_en    = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(valid_a), 32'h0);
        chk("rst_instr", 32'(instr_a), 32'h0);
        chk("rst_pcplus", 32'(pcplus_a), 32'h0);
        chk("rst_req", 32'(req_a), 32'h0);
        chk("rst_addr", 32'(addr_a), 32'h0);
        chk("rst_addr_wrap", 32'(addr_b), 32'hFFFF);
        rst = 1'b0;
        chk("idle_valid", 32'(valid_a), 32'h0);
        chk("idle_req", 32'(req_a), 32'h0);

        step();
        chk("e0_addr", 32'(addr_a), 32'h0);
        chk("e0_req", 32'(req_a), 32'h1);
        chk("e0_valid", 32'(valid_a), 32'h0);

        step();
        chk("e1_valid", 32'(valid_a), 32'h1);
        chk("e1_instr", 32'(instr_a), 32'h3000);
        chk("e1_pcplus", 32'(pcplus_a), 32'h1);
        chk("e1_addr", 32'(addr_a), 32'h1);
        chk("wrap_pcplus", 32'(pcplus_b), 32'h0000);
        chk("wrap_instr", 32'(instr_b), 32'h3FFF);
        chk("wrap_addr", 32'(addr_b), 32'h0000);

        step();
        chk("e2_pcplus", 32'(pcplus_a), 32'h2);
        chk("e2_addr", 32'(addr_a), 32'h2);
        chk("wrap_addr2", 32'(addr_b), 32'h0001);
        step();
        chk("e3_pcplus", 32'(pcplus_a), 32'h3);
        chk("e3_addr", 32'(addr_a), 32'h3);
        step();
        chk("e4_pcplus", 32'(pcplus_a), 32'h4);
        step();
        chk("e5_pcplus", 32'(pcplus_a), 32'h5);
        chk("e5_instr", 32'(instr_a), 32'h3400);
        chk("e5_addr", 32'(addr_a), 32'h5);

        IFIDWrite = 1'b0;
        PCWrite   = 1'b0;
        step();
        chk("stall_instr", 32'(instr_a), 32'h3400);
        chk("stall_pcplus", 32'(pcplus_a), 32'h5);
        chk("stall_addr", 32'(addr_a), 32'h5);
        chk("stall_req", 32'(req_a), 32'h0);

        IFIDWrite = 1'b1;
        PCWrite   = 1'b1;
        step();
        chk("held_instr", 32'(instr_a), 32'h3500);
        chk("held_pcplus", 32'(pcplus_a), 32'h6);
        chk("held_valid", 32'(valid_a), 32'h1);
        chk("held_rs", 32'(rs_a), 32'h5);
        chk("held_rt", 32'(rt_a), 32'h0);
        chk("post_addr", 32'(addr_a), 32'h6);
        chk("fetch5_once", 32'(fetch5), 32'h1);

        IFIDWrite = 1'b0;
        PCWrite   = 1'b0;
        step();
        chk("s1_instr", 32'(instr_a), 32'h3500);
        chk("s1_req", 32'(req_a), 32'h0);
        BrTaken  = 1'b1;
        BrTarget = 16'h0040;
        step();
        chk("br_valid", 32'(valid_a), 32'h0);
        chk("br_instr", 32'(instr_a), 32'h0);
        chk("br_pcplus", 32'(pcplus_a), 32'h6);
        chk("br_addr", 32'(addr_a), 32'h40);
        chk("br_req", 32'(req_a), 32'h1);
        BrTaken = 1'b0;
        step();
        chk("s3_valid", 32'(valid_a), 32'h0);
        chk("s3_req", 32'(req_a), 32'h0);
        IFIDWrite = 1'b1;
        PCWrite   = 1'b1;
        step();
        chk("tgt_instr", 32'(instr_a), 32'h3040);
        chk("tgt_pcplus", 32'(pcplus_a), 32'h41);
        chk("tgt_rt", 32'(rt_a), 32'h4);
        chk("tgt_addr", 32'(addr_a), 32'h41);

        BrTaken  = 1'b1;
        BrTarget = 16'h0008;
        step();
        chk("r8_addr", 32'(addr_a), 32'h8);
        chk("r8_pcplus", 32'(pcplus_a), 32'h41);
        BrTaken = 1'b0;
        ack_en  = 1'b0;
        step();
        chk("w1_valid", 32'(valid_a), 32'h0);
        chk("w1_instr", 32'(instr_a), 32'h0);
        chk("w1_addr", 32'(addr_a), 32'h8);
        step();
        chk("w2_valid", 32'(valid_a), 32'h0);
        chk("w2_instr", 32'(instr_a), 32'h0);
        chk("w2_addr", 32'(addr_a), 32'h8);
        ack_en = 1'b1;
        step();
        chk("w3_instr", 32'(instr_a), 32'h3800);
        chk("w3_pcplus", 32'(pcplus_a), 32'h9);
        chk("w3_valid", 32'(valid_a), 32'h1);

        IFIDWrite = 1'b0;
        PCWrite   = 1'b0;
        step();
        chk("h_req", 32'(req_a), 32'h0);
        chk("h_instr", 32'(instr_a), 32'h3800);
`ifdef FETCH_STATS_EN
        chk("stall_cnt", 32'(stall_a), 32'd5);
        chk("bubble_cnt", 32'(bubble_a), 32'd4);
`endif
        rst       = 1'b1;
        BrTaken   = 1'b1;
        BrTarget  = 16'h0077;
        IFIDWrite = 1'b1;
        PCWrite   = 1'b1;
        step();
        chk("hr_valid", 32'(valid_a), 32'h0);
        chk("hr_instr", 32'(instr_a), 32'h0);
        chk("hr_pcplus", 32'(pcplus_a), 32'h0);
        chk("hr_req", 32'(req_a), 32'h0);
        chk("hr_addr", 32'(addr_a), 32'h0);
`ifdef FETCH_STATS_EN
        chk("hr_stall", 32'(stall_a), 32'h0);
        chk("hr_bubble", 32'(bubble_a), 32'h0);
`endif
        rst     = 1'b0;
        BrTaken = 1'b0;
        step();
        chk("rs_addr", 32'(addr_a), 32'h0);
        chk("rs_req", 32'(req_a), 32'h1);
        chk("rs_valid", 32'(valid_a), 32'h0);
        step();
        chk("rs_instr", 32'(instr_a), 32'h3000);
        chk("rs_pcplus", 32'(pcplus_a), 32'h1);
        chk("no_leak", 32'(leak), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
